aes_decrypt_sequencer: RTL and testbench

//  Control FSM for the iterative AES-128 decryption datapath behind the AES Avalon peripheral.

---
 rtl/aes_decrypt_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_aes_decrypt_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_sequencer.sv
// AES-128 inverse-cipher control FSM: key expansion, ciphertext load,
// then per-round InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns.
// Ports: clk_clk, reset_reset_n (async low); start, ks_done in;
//   ks_start, state_ld_init, state_we, op_sel[2:0], mix_col[1:0],
//   rk_idx[3:0], busy, done out (Moore, all 0 in reset/IDLE).
module aes_decrypt_sequencer #(
  parameter int NROUNDS = 10,
  parameter int SUB_LAT = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       start,
  input  logic       ks_done,
  output logic       ks_start,
  output logic       state_ld_init,
  output logic       state_we,
  output logic [2:0] op_sel,
  output logic [1:0] mix_col,
  output logic [3:0] rk_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_ADDK  = 3'd1;
  localparam logic [2:0] OP_ISHF  = 3'd2;
  localparam logic [2:0] OP_ISUB  = 3'd3;
  localparam logic [2:0] OP_IMIX  = 3'd4;

  localparam logic [3:0] RK_TOP   = 4'(NROUNDS);
  localparam logic [1:0] SUB_LAST = 2'(SUB_LAT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_KEYEXP,
    S_INIT,
    S_ARK0,
    S_ISR,
    S_ISB,
    S_ARK,
    S_IMC,
    S_FISR,
    S_FISB,
    S_FARK,
    S_DONE
  } state_t;

  state_t     st, st_nx;
  logic [3:0] rnd, rnd_nx;
  // cnt: ISB wait cycle or IMC column, depending on state
  logic [1:0] cnt, cnt_nx;
  logic       ke_first, ke_first_nx;
  logic       run;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      st       <= S_IDLE;
      rnd      <= 4'd0;
      cnt      <= 2'd0;
      ke_first <= 1'b0;
    end else begin
      st       <= st_nx;
      rnd      <= rnd_nx;
      cnt      <= cnt_nx;
      ke_first <= ke_first_nx;
    end
  end

  assign run = (st != S_IDLE) && (st != S_DONE);

  always_comb begin
    st_nx       = st;
    rnd_nx      = rnd;
    cnt_nx      = cnt;
    ke_first_nx = 1'b0;
    unique case (st)
      S_IDLE: begin
        rnd_nx = 4'd0;
        cnt_nx = 2'd0;
        if (start) begin
          st_nx       = S_KEYEXP;
          ke_first_nx = 1'b1;
        end
      end
      S_KEYEXP: if (ks_done) st_nx = S_INIT;
      S_INIT:   st_nx = S_ARK0;
      S_ARK0: begin
        st_nx  = S_ISR;
        rnd_nx = RK_TOP - 4'd1;
      end
      S_ISR: begin
        st_nx  = S_ISB;
        cnt_nx = 2'd0;
      end
      S_ISB: begin
        if (cnt == SUB_LAST) begin
          st_nx  = S_ARK;
          cnt_nx = 2'd0;
        end else begin
          cnt_nx = cnt + 2'd1;
        end
      end
      S_ARK: begin
        st_nx  = S_IMC;
        cnt_nx = 2'd0;
      end
      S_IMC: begin
        cnt_nx = cnt + 2'd1;
        if (cnt == 2'd3) begin
          cnt_nx = 2'd0;
          // last middle round leaves rnd at 1; never decremented to 0
          if (rnd > 4'd1) begin
            rnd_nx = rnd - 4'd1;
            st_nx  = S_ISR;
          end else begin
            st_nx  = S_FISR;
          end
        end
      end
      S_FISR: begin
        st_nx  = S_FISB;
        cnt_nx = 2'd0;
      end
      S_FISB: begin
        if (cnt == SUB_LAST) begin
          st_nx  = S_FARK;
          cnt_nx = 2'd0;
        end else begin
          cnt_nx = cnt + 2'd1;
        end
      end
      S_FARK: st_nx = S_DONE;
      S_DONE: if (!start) st_nx = S_IDLE;
      default: st_nx = S_IDLE;
    endcase
    // dropping start aborts any in-flight run
    if (run && !start) begin
      st_nx       = S_IDLE;
      rnd_nx      = 4'd0;
      cnt_nx      = 2'd0;
      ke_first_nx = 1'b0;
    end
  end

  always_comb begin
    ks_start      = 1'b0;
    state_ld_init = 1'b0;
    state_we      = 1'b0;
    op_sel        = OP_NOP;
    mix_col       = 2'd0;
    rk_idx        = 4'd0;
    busy          = run;
    done          = (st == S_DONE);
    unique case (st)
      S_KEYEXP: ks_start = ke_first;
      S_INIT:   state_ld_init = 1'b1;
      S_ARK0: begin
        op_sel   = OP_ADDK;
        rk_idx   = RK_TOP;
        state_we = 1'b1;
      end
      S_ISR, S_FISR: begin
        op_sel   = OP_ISHF;
        state_we = 1'b1;
      end
      S_ISB, S_FISB: begin
        op_sel   = OP_ISUB;
        state_we = (cnt == SUB_LAST);
      end
      S_ARK: begin
        op_sel   = OP_ADDK;
        rk_idx   = rnd;
        state_we = 1'b1;
      end
      S_IMC: begin
        op_sel   = OP_IMIX;
        mix_col  = cnt;
        rk_idx   = rnd;
        state_we = 1'b1;
      end
      S_FARK: begin
        op_sel   = OP_ADDK;
        state_we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Directed bench for aes_decrypt_sequencer (default build and SUB_LAT=2).
// Checks reset, full-run sequencing, latency, abort and done handshake.
module tb_aes_decrypt_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ks_done = 1'b0;
  logic       ks_start, state_ld_init, state_we, busy, done;
  logic [2:0] op_sel;
  logic [1:0] mix_col;
  logic [3:0] rk_idx;

  logic       start2 = 1'b0;
  logic       ks_done2 = 1'b0;
  logic       ks_start2, state_ld_init2, state_we2, busy2, done2;
  logic [2:0] op_sel2;
  logic [1:0] mix_col2;
  logic [3:0] rk_idx2;

  aes_decrypt_sequencer dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .start         (start),
    .ks_done       (ks_done),
    .ks_start      (ks_start),
    .state_ld_init (state_ld_init),
    .state_we      (state_we),
    .op_sel        (op_sel),
    .mix_col       (mix_col),
    .rk_idx        (rk_idx),
    .busy          (busy),
    .done          (done)
  );

  aes_decrypt_sequencer #(.NROUNDS(10), .SUB_LAT(2)) dut2 (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .start         (start2),
    .ks_done       (ks_done2),
    .ks_start      (ks_start2),
    .state_ld_init (state_ld_init2),
    .state_we      (state_we2),
    .op_sel        (op_sel2),
    .mix_col       (mix_col2),
    .rk_idx        (rk_idx2),
    .busy          (busy2),
    .done          (done2)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs();
    return int'({ks_start, state_ld_init, state_we, op_sel,
                 mix_col, rk_idx, busy, done});
  endfunction

  int q_ark[$];
  int wes, imc_cyc, imc_bad, isb_cyc, isb_bad, isb_run;
  logic [1:0] imc_col;

  // Raise start, hold ks_done low for kd_wait KEYEXP cycles, then count
  // edges after ks_done is presented until done is seen.
  task automatic run_seq(input int kd_wait, output int lat);
    q_ark.delete();
    wes = 0; imc_cyc = 0; imc_bad = 0;
    isb_cyc = 0; isb_bad = 0; isb_run = 0;
    imc_col = 2'd0;
    start = 1'b1;
    ks_done = 1'b0;
    step();
    for (int i = 1; i < kd_wait; i++) step();
    ks_done = 1'b1;
    lat = 0;
    while (!done && lat < 300) begin
      step();
      lat++;
      if (state_we) wes++;
      if (op_sel == 3'd1 && state_we) q_ark.push_back(int'(rk_idx));
      if (op_sel == 3'd4) begin
        imc_cyc++;
        if (mix_col != imc_col || !state_we || q_ark.size() == 0)
          imc_bad++;
        else if (int'(rk_idx) != q_ark[$])
          imc_bad++;
        imc_col = imc_col + 2'd1;
      end
      if (op_sel == 3'd3) begin
        isb_cyc++;
        isb_run++;
        if (state_we != (isb_run == 2)) isb_bad++;
      end else begin
        isb_run = 0;
      end
    end
  endtask

  int lat, cnt, ks_n, lost;
  int isb2_cyc, isb2_bad, isb2_run;

  initial begin
    #2;
    chk("reset_outs", outs(), 0);
    chk("reset_outs2", int'({busy2, done2, state_we2}), 0);
    #10 rst_n = 1'b1;
    step();
    chk("idle_outs", outs(), 0);

    // full run, ks_done after 5 KEYEXP cycles
    run_seq(5, lat);
    chk("latency", lat, 79);
    chk("we_pulses", wes, 67);
    chk("ark_count", q_ark.size(), 11);
    for (int i = 0; i < 11 && i < q_ark.size(); i++)
      chk($sformatf("ark_rk%0d", i), q_ark[i], 10 - i);
    chk("imc_cycles", imc_cyc, 36);
    chk("imc_pattern", imc_bad, 0);
    chk("isb_cycles", isb_cyc, 20);
    chk("isb_we_last", isb_bad, 0);
    chk("done_busy", int'(busy), 0);
    start = 1'b0;
    step();
    chk("done_clear", int'(done), 0);

    // async reset in the middle of IMC
    start = 1'b1;
    ks_done = 1'b1;
    cnt = 0;
    while (op_sel != 3'd4 && cnt < 100) begin
      step();
      cnt++;
    end
    chk("reached_imc", int'(op_sel), 4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", outs(), 0);
    ks_done = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk("rst_ks_start", int'(ks_start), 1);
    ks_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ks_start) ks_n++;
    end
    chk("rst_ks_once", ks_n, 1);
    start = 1'b0;
    step();
    chk("rst_idle", outs(), 0);

    // abort 30 cycles into a run, then restart
    start = 1'b1;
    ks_done = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("abort_busy_pre", int'(busy), 1);
    start = 1'b0;
    step();
    chk("abort_outs", outs(), 0);
    lost = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done || busy) lost++;
    end
    chk("abort_no_done", lost, 0);
    run_seq(1, lat);
    chk("restart_latency", lat, 79);
    chk("restart_we", wes, 67);

    // start held after done
    lost = 0;
    ks_n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!done) lost++;
      if (ks_start) ks_n++;
    end
    chk("done_held", lost, 0);
    chk("done_no_ks", ks_n, 0);
    start = 1'b0;
    step();
    chk("done_drop", int'(done), 0);
    chk("done_drop_outs", outs(), 0);

    // SUB_LAT=2 with ks_done already high on first KEYEXP cycle
    start2 = 1'b1;
    ks_done2 = 1'b1;
    step();
    chk("sl2_ks_start", int'(ks_start2), 1);
    lat = 0; isb2_cyc = 0; isb2_bad = 0; isb2_run = 0;
    while (!done2 && lat < 300) begin
      step();
      lat++;
      if (op_sel2 == 3'd3) begin
        isb2_cyc++;
        isb2_run++;
        if (state_we2 != (isb2_run == 3)) isb2_bad++;
      end else begin
        isb2_run = 0;
      end
    end
    chk("sl2_latency", lat, 89);
    chk("sl2_isb_cycles", isb2_cyc, 30);
    chk("sl2_isb_we", isb2_bad, 0);
    start2 = 1'b0;
    step();
    chk("sl2_done_clear", int'(done2), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
